fmul_rr_scheduler: RTL and testbench

- Shares one pipelined Field_Multiplier (a*b mod 2^255-19, 256-bit operands, 255-bit result) between N_REQ requesters.
- Grants one requester per cycle using round-robin arbitration and registers the granted operands onto the multiplier inputs.
- Tracks in-flight operations with a tag pipeline matched to the multiplier latency, then routes each result back to its originator with a one-hot valid.
- Sits between the point-arithmetic sequencers and the single multiplier instance.

---
 rtl/fmul_rr_scheduler.sv | 145 ++++++++++++++
 tb/tb_fmul_rr_scheduler.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmul_rr_scheduler.sv
// Round-robin front end that shares one pipelined field multiplier between N_REQ requesters.
// Optional perf counters (perf_ops, perf_stall) are compiled in when FMUL_SCHED_PERF_EN is defined.
module fmul_rr_scheduler #(
    parameter int N_REQ   = 4,
    parameter int MUL_LAT = 3,
    parameter int DW      = 256,
    parameter int RW      = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sched_en,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ*DW-1:0]   req_a,
    input  logic [N_REQ*DW-1:0]   req_b,
    output logic [N_REQ-1:0]      req_ready,
    output logic [DW-1:0]         mul_a,
    output logic [DW-1:0]         mul_b,
    input  logic [RW-1:0]         mul_result,
    output logic [N_REQ-1:0]      resp_valid,
    output logic [RW-1:0]         resp_data,
    output logic                  busy
`ifdef FMUL_SCHED_PERF_EN
    ,
    output logic [31:0]           perf_ops,
    output logic [31:0]           perf_stall
`endif
);

    localparam int TW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [TW-1:0] ptr_q, ptr_d;
    logic [TW-1:0] gnt_idx;
    logic [TW-1:0] cand;
    logic          hs;

    logic [DW-1:0] mul_a_q, mul_a_d;
    logic [DW-1:0] mul_b_q, mul_b_d;

    logic [MUL_LAT-1:0] tag_vld_q;
    logic [TW-1:0]      tag_q [MUL_LAT];

    logic          tail_vld;
    logic [TW-1:0] tail_tag;

    // Grant: first valid requester at or after the pointer, wrapping modulo N_REQ.
    always_comb begin
        req_ready = '0;
        gnt_idx   = '0;
        cand      = '0;
        hs        = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = TW'((int'(ptr_q) + k) % N_REQ);
            if (!hs && sched_en && req_valid[cand]) begin
                hs      = 1'b1;
                gnt_idx = cand;
            end
        end
        if (hs) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d   = ptr_q;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        if (hs) begin
            ptr_d   = (gnt_idx == TW'(N_REQ - 1)) ? '0 : gnt_idx + TW'(1);
            mul_a_d = req_a[gnt_idx*DW +: DW];
            mul_b_d = req_b[gnt_idx*DW +: DW];
        end
    end

    // Stage boundary: operand registers feeding the multiplier, plus tag valid bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q     <= '0;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            tag_vld_q <= '0;
        end else begin
            ptr_q        <= ptr_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            tag_vld_q[0] <= hs;
            for (int s = 1; s < MUL_LAT; s++) begin
                tag_vld_q[s] <= tag_vld_q[s-1];
            end
        end
    end

    // Tag ids are qualified by tag_vld_q, so they need no reset.
    always_ff @(posedge clk) begin
        tag_q[0] <= gnt_idx;
        for (int s = 1; s < MUL_LAT; s++) begin
            tag_q[s] <= tag_q[s-1];
        end
    end

    assign tail_vld = tag_vld_q[MUL_LAT-1];
    assign tail_tag = tag_q[MUL_LAT-1];

    always_comb begin
        resp_valid = '0;
        for (int i = 0; i < N_REQ; i++) begin
            resp_valid[i] = tail_vld && (tail_tag == TW'(i));
        end
    end

    assign resp_data = mul_result;
    assign busy      = |tag_vld_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;

`ifdef FMUL_SCHED_PERF_EN
    logic [31:0] perf_ops_q, perf_ops_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    // Stall means someone is waiting but no grant went out, which only happens with sched_en low.
    always_comb begin
        perf_ops_d   = perf_ops_q;
        perf_stall_d = perf_stall_q;
        if (hs) begin
            perf_ops_d = perf_ops_q + 32'd1;
        end
        if ((|req_valid) && !hs && (perf_stall_q != '1)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_ops_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_ops_q   <= perf_ops_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_ops   = perf_ops_q;
    assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_fmul_rr_scheduler.sv
// Scoreboard bench for fmul_rr_scheduler: directed grants, a modeled 3-cycle field multiplier,
// and a monitor that checks every response against queued expectations.
module tb_fmul_rr_scheduler;

    localparam int N_REQ   = 4;
    localparam int MUL_LAT = 3;
    localparam int DW      = 256;
    localparam int RW      = 255;

    logic                clk;
    logic                rst;
    logic                sched_en;
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ*DW-1:0] req_a;
    logic [N_REQ*DW-1:0] req_b;
    logic [N_REQ-1:0]    req_ready;
    logic [DW-1:0]       mul_a;
    logic [DW-1:0]       mul_b;
    logic [RW-1:0]       mul_result;
    logic [N_REQ-1:0]    resp_valid;
    logic [RW-1:0]       resp_data;
    logic                busy;
`ifdef FMUL_SCHED_PERF_EN
    logic [31:0]         perf_ops;
    logic [31:0]         perf_stall;
`endif

    fmul_rr_scheduler #(
        .N_REQ  (N_REQ),
        .MUL_LAT(MUL_LAT),
        .DW     (DW),
        .RW     (RW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sched_en  (sched_en),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_result(mul_result),
        .resp_valid(resp_valid),
        .resp_data (resp_data),
        .busy      (busy)
`ifdef FMUL_SCHED_PERF_EN
        ,
        .perf_ops  (perf_ops),
        .perf_stall(perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference multiplier: a*b mod 2^255-19 by shift-and-add.
    function automatic logic [RW-1:0] modmul(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [257:0] p, x, r;
        p = (258'd1 << 255) - 258'd19;
        x = {2'b00, a};
        for (int k = 0; k < 3; k++) if (x >= p) x = x - p;
        r = '0;
        for (int i = DW - 1; i >= 0; i--) begin
            r = r << 1;
            if (r >= p) r = r - p;
            if (b[i]) begin
                r = r + x;
                if (r >= p) r = r - p;
            end
        end
        return r[RW-1:0];
    endfunction

    // Two registers after the operand registers give a 3-cycle multiplier.
    logic [RW-1:0] m1, m2;
    always @(posedge clk) begin
        m1 <= modmul(mul_a, mul_b);
        m2 <= m1;
    end
    assign mul_result = m2;

    typedef struct {
        logic [N_REQ-1:0] oh;
        logic [RW-1:0]    data;
        int               cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every presented response must match the head of the scoreboard, in the right cycle.
    always @(negedge clk) begin
        if (!rst && resp_valid != '0) begin
            exp_t e;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL resp_unexpected: got valid=%b data=%0h expected no response", resp_valid, resp_data);
            end else begin
                e = sb.pop_front();
                if (resp_valid !== e.oh || resp_data !== e.data || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL resp: got valid=%b data=%0h cyc=%0d expected valid=%b data=%0h cyc=%0d",
                             resp_valid, resp_data, cyc, e.oh, e.data, e.cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
        req_a[i*DW +: DW] = a;
        req_b[i*DW +: DW] = b;
    endtask

    // Checks the grant in the current cycle, queues the response, and advances past the edge.
    task automatic grant(input logic [N_REQ-1:0] oh, input logic [RW-1:0] data, input string name);
        exp_t e;
        @(negedge clk);
        chk(name, 256'(req_ready), 256'(oh));
        if (oh != '0) begin
            e.oh   = oh;
            e.data = data;
            e.cyc  = cyc + MUL_LAT;
            sb.push_back(e);
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    logic [DW-1:0] big_a, big_b;

    initial begin
        big_a     = 256'd1 << 130;
        big_b     = 256'd1 << 125;
        rst       = 1'b0;
        sched_en  = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        #2 rst = 1'b1;

        @(negedge clk);
        chk("rst_mul_a", mul_a, 0);
        chk("rst_mul_b", mul_b, 0);
        chk("rst_busy", 256'(busy), 0);
        chk("rst_resp_valid", 256'(resp_valid), 0);
        chk("rst_req_ready", 256'(req_ready), 0);
        tick();
        tick();
        rst      = 1'b0;
        sched_en = 1'b1;

        // Single op on requester 2
        set_op(2, 9, 11);
        req_valid = 4'b0100;
        grant(4'b0100, 99, "single_grant");
        req_valid = '0;
        chk("single_mul_a", mul_a, 9);
        chk("single_mul_b", mul_b, 11);
        for (int s = 0; s < MUL_LAT; s++) begin
            @(negedge clk);
            chk("single_busy", 256'(busy), 1);
            tick();
        end
        @(negedge clk);
        chk("single_idle", 256'(busy), 0);
        tick();

        // Pointer is 3; only requester 0 valid must wrap to it. 2^255 mod p = 19.
        set_op(0, big_a, big_b);
        req_valid = 4'b0001;
        grant(4'b0001, 19, "wrap_grant");
        chk("wrap_mul_a", mul_a, big_a);

        // Pointer is 1: with req 0 and req 1 valid, req 1 wins.
        set_op(1, 6, 7);
        req_valid = 4'b0011;
        grant(4'b0010, 42, "ptr1_prio");

        set_op(3, 3, 3);
        req_valid = 4'b1000;
        grant(4'b1000, 9, "grant3");

        // Pointer is 0: all valid rotates 0,1,2,3,0.
        set_op(0, 2, 3);
        set_op(1, 25, 35);
        set_op(2, 4, 5);
        set_op(3, 7, 8);
        req_valid = 4'b1111;
        grant(4'b0001, 6,   "rr0");
        grant(4'b0010, 875, "rr1");
        grant(4'b0100, 20,  "rr2");
        grant(4'b1000, 56,  "rr3");
        grant(4'b0001, 6,   "rr4");

        // Scheduler disabled with requester 1 waiting; in-flight ops drain.
        sched_en  = 1'b0;
        req_valid = 4'b0010;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            chk("stall_ready", 256'(req_ready), 0);
            if (s == 0) chk("stall_busy_early", 256'(busy), 1);
            if (s == 4) chk("stall_busy_drained", 256'(busy), 0);
            tick();
        end
`ifdef FMUL_SCHED_PERF_EN
        chk("perf_stall", 256'(perf_stall), 5);
`endif
        sched_en = 1'b1;
        grant(4'b0010, 875, "resume");
        req_valid = '0;
`ifdef FMUL_SCHED_PERF_EN
        chk("perf_ops", 256'(perf_ops), 10);
`endif
        for (int w = 0; w < 10 && sb.size() != 0; w++) tick();
        chk("drain_empty", 256'(sb.size()), 0);
        tick();

        // Two grants, then reset while both are in flight.
        set_op(2, 9, 11);
        set_op(3, 3, 3);
        req_valid = 4'b1100;
        @(negedge clk);
        chk("rstmid_grant2", 256'(req_ready), 256'(4'b0100));
        tick();
        @(negedge clk);
        chk("rstmid_grant3", 256'(req_ready), 256'(4'b1000));
        tick();
        req_valid = '0;
        rst = 1'b1;
        #1;
        chk("rstmid_mul_a", mul_a, 0);
        chk("rstmid_busy", 256'(busy), 0);
        chk("rstmid_resp_valid", 256'(resp_valid), 0);
        req_valid = 4'b1111;
        #1;
        chk("rstmid_ptr", 256'(req_ready), 256'(4'b0001));
        req_valid = '0;
        tick();
        tick();
        rst = 1'b0;
`ifdef FMUL_SCHED_PERF_EN
        chk("perf_ops_rst", 256'(perf_ops), 0);
`endif
        for (int w = 0; w < 6; w++) tick();

        set_op(2, 9, 11);
        req_valid = 4'b0100;
        grant(4'b0100, 99, "post_reset");
        req_valid = '0;
        for (int w = 0; w < 6; w++) tick();
        chk("final_empty", 256'(sb.size()), 0);
        chk("final_busy", 256'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
